// File: rtl/pow4_phase_pkg.sv
// pow4_phase_pkg: shared constants, FSM states and CORDIC arctangent table
// Provides GUARD (CORDIC headroom bits), state_t and atan_lut(), which scales
// atan(2^-k) into phase units where pi = 2^(nbw_ph-1); valid for nbw_ph <= 15.
package pow4_phase_pkg;

    localparam int GUARD = 2;

    typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

    // atan(2^-k) with pi = 2^15, rounded into the target phase width below
    localparam int ATAN_Q15 [9] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41};

    function automatic int atan_lut(input int k, input int nbw_ph);
        int s;
        s = 16 - nbw_ph;
        if (k > 8)
            return 0;
        return (ATAN_Q15[k] + (1 << (s - 1))) >> s;
    endfunction

endpackage

// File: rtl/pow4_phase_est_cordic.sv
// cordic_vect_iter: one CORDIC vectoring micro-rotation, shift amount k
// Ports: x/y/z current vector and angle, k iteration index;
// x_nxt/y_nxt/z_nxt rotated vector and accumulated angle.
module cordic_vect_iter
    import pow4_phase_pkg::*;
#(
    parameter int W      = 15,
    parameter int NBW_PH = 10
) (
    input  logic signed [W-1:0]      x,
    input  logic signed [W-1:0]      y,
    input  logic signed [NBW_PH-1:0] z,
    input  logic        [3:0]        k,
    output logic signed [W-1:0]      x_nxt,
    output logic signed [W-1:0]      y_nxt,
    output logic signed [NBW_PH-1:0] z_nxt
);

    logic signed [NBW_PH-1:0] atan_tab [16];
    logic signed [W-1:0]      xs, ys;
    logic                     neg;

    for (genvar j = 0; j < 16; j++) begin : g_atan
        assign atan_tab[j] = NBW_PH'(atan_lut(j, NBW_PH));
    end

    // rotate toward the x axis; both updates use the pre-iteration x and y
    always_comb begin
        neg   = y[W-1];
        xs    = x >>> k;
        ys    = y >>> k;
        x_nxt = neg ? x - ys : x + ys;
        y_nxt = neg ? y + xs : y - xs;
        z_nxt = neg ? z - atan_tab[k] : z + atan_tab[k];
    end

endmodule

// File: rtl/pow4_phase_est.sv
// pow4_phase_est: carrier phase estimate from a 4th-power QPSK symbol stream
// Block-averages 2^LOG2_AVG samples, runs a multi-cycle CORDIC vectoring atan2
// on the block sums and divides the angle by 4.
// Ports: clk; rst_async_n asynchronous active-low reset; i_valid, i_data_i,
// i_data_q input samples; o_phase signed estimate (pi = 2^(NBW_PH-1)) with
// one-cycle o_valid strobe; o_overrun strobes when a completed block is
// dropped because the CORDIC is still busy.
// Build option: define POW4_PHASE_UNWRAP_EN to unwrap the pi/2 ambiguity
// jumps of o_phase against the previous output.
module pow4_phase_est
    import pow4_phase_pkg::*;
#(
    parameter int NBW_IN   = 9,
    parameter int NBI_IN   = 2,
    parameter int LOG2_AVG = 4,
    parameter int NB_ITER  = 8,
    parameter int NBW_PH   = 10
) (
    input  logic                     clk,
    input  logic                     rst_async_n,
    input  logic                     i_valid,
    input  logic signed [NBW_IN-1:0] i_data_i,
    input  logic signed [NBW_IN-1:0] i_data_q,
    output logic signed [NBW_PH-1:0] o_phase,
    output logic                     o_valid,
    output logic                     o_overrun
);

    localparam int NBW_ACC = NBW_IN + LOG2_AVG;
    localparam int W       = NBW_ACC + GUARD;

    if (NB_ITER < 1 || NB_ITER > 9 || NBI_IN > NBW_IN) begin : g_bad_param
        $error("pow4_phase_est: illegal parameter set");
    end

    logic signed [NBW_ACC-1:0] acc_i, acc_q, sum_i, sum_q;
    logic        [LOG2_AVG-1:0] cnt;
    logic signed [W-1:0]       x, y, x_nxt, y_nxt;
    logic signed [NBW_PH-1:0]  z, z_nxt, phi_raw, phase_nxt;
    logic        [3:0]         k;
    logic                      blk_done;
    state_t                    state, state_nxt;

    assign sum_i    = acc_i + {{LOG2_AVG{i_data_i[NBW_IN-1]}}, i_data_i};
    assign sum_q    = acc_q + {{LOG2_AVG{i_data_q[NBW_IN-1]}}, i_data_q};
    assign blk_done = i_valid && (cnt == '1);
    assign phi_raw  = z >>> 2;

`ifdef POW4_PHASE_UNWRAP_EN
    // o_phase doubles as the history: pick the pi/2 alias of phi_raw nearest to it
    assign phase_nxt = phi_raw - ((phi_raw - o_phase + NBW_PH'(1 << (NBW_PH - 3)))
                                  & ~NBW_PH'((1 << (NBW_PH - 2)) - 1));
`else
    assign phase_nxt = phi_raw;
`endif

    cordic_vect_iter #(.W(W), .NBW_PH(NBW_PH)) u_iter (
        .x     (x),
        .y     (y),
        .z     (z),
        .k     (k),
        .x_nxt (x_nxt),
        .y_nxt (y_nxt),
        .z_nxt (z_nxt)
    );

    always_ff @(posedge clk or negedge rst_async_n)
        if (!rst_async_n) begin
            acc_i <= '0;
            acc_q <= '0;
            cnt   <= '0;
        end else if (i_valid) begin
            acc_i <= blk_done ? '0 : sum_i;
            acc_q <= blk_done ? '0 : sum_q;
            cnt   <= cnt + 1'b1;
        end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = blk_done ? LOAD : IDLE;
            LOAD: state_nxt = ITER;
            ITER: state_nxt = (k == 4'(NB_ITER - 1)) ? DONE : ITER;
            DONE: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_async_n)
        if (!rst_async_n) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            k         <= '0;
            o_phase   <= '0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_valid   <= state == DONE;
            o_overrun <= blk_done && state != IDLE;
            if (state == IDLE && blk_done) begin
                x <= {{GUARD{sum_i[NBW_ACC-1]}}, sum_i};
                y <= {{GUARD{sum_q[NBW_ACC-1]}}, sum_q};
            end
            // left half-plane: rotate by pi first so the CORDIC converges
            if (state == LOAD) begin
                x <= x[W-1] ? -x : x;
                y <= x[W-1] ? -y : y;
                z <= x[W-1] ? {1'b1, {(NBW_PH-1){1'b0}}} : '0;
                k <= '0;
            end
            if (state == ITER) begin
                x <= x_nxt;
                y <= y_nxt;
                z <= z_nxt;
                k <= k + 1'b1;
            end
            if (state == DONE)
                o_phase <= phase_nxt;
        end

endmodule
